// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: two-requester AXI4 read-channel arbiter.
// One burst is outstanding at a time. Address requests are granted
// round-robin: when both requesters ask together, prio_reg picks the winner,
// and after each burst the other requester gets priority. Read data is routed
// back to the granted requester with zero latency. len_err is a sticky flag
// that is set when the number of beats does not match the granted arlen.
`timescale 1ns/1ps

module dma_rd_arbiter #(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        arstn,
    // requester 0
    input  logic [C_AXI_ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]                  s0_arlen,
    input  logic                        s0_arvalid,
    output logic                        s0_arready,
    output logic [C_AXI_DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]                  s0_rresp,
    output logic                        s0_rlast,
    output logic                        s0_rvalid,
    input  logic                        s0_rready,
    // requester 1
    input  logic [C_AXI_ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]                  s1_arlen,
    input  logic                        s1_arvalid,
    output logic                        s1_arready,
    output logic [C_AXI_DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]                  s1_rresp,
    output logic                        s1_rlast,
    output logic                        s1_rvalid,
    input  logic                        s1_rready,
    // shared master port
    output logic [C_AXI_ID_WIDTH-1:0]   m_arid,
    output logic [C_AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [C_AXI_ID_WIDTH-1:0]   m_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rlast,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    output logic                        len_err
);

    localparam logic [2:0] ARSIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t                      state_reg;
    logic                        prio_reg;
    logic                        idx_reg;
    logic                        len_err_reg;
    logic                        m_arvalid_reg;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]                  len_reg;
    logic [8:0]                  beat_cnt_reg;

    // Requester signals gathered into vectors so per-requester logic is generated.
    logic [1:0]                        req_arvalid;
    logic [1:0]                        req_rready;
    logic [1:0]                        req_arready;
    logic [1:0]                        req_rvalid;
    logic [1:0]                        req_rlast;
    logic [1:0]                        grant;
    logic [1:0]                        route;
    logic [1:0][C_AXI_ADDR_WIDTH-1:0]  req_araddr;
    logic [1:0][7:0]                   req_arlen;

    logic in_idle;
    logic in_data;
    logic win_idx;
    logic accept;
    logic beat;
    logic unused_rid;

    assign req_arvalid = {s1_arvalid, s0_arvalid};
    assign req_rready  = {s1_rready, s0_rready};
    assign req_araddr  = {s1_araddr, s0_araddr};
    assign req_arlen   = {s1_arlen, s0_arlen};

    // The ID returned on the read channel is not needed: only one burst is ever in flight.
    assign unused_rid = ^m_rid;

    // Gating with arstn keeps arready low for the whole reset cycle, not just after an edge.
    assign in_idle = (state_reg == ST_IDLE) && arstn;
    assign in_data = (state_reg == ST_DATA);

    // Lone requester wins; on a tie the priority pointer decides.
    assign grant[0] = req_arvalid[0] & (~req_arvalid[1] | ~prio_reg);
    assign grant[1] = req_arvalid[1] & (~req_arvalid[0] |  prio_reg);
    assign win_idx  = grant[1];
    assign accept   = in_idle & (|req_arvalid);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            localparam logic SEL_IDX = (gi == 1);
            assign req_arready[gi] = in_idle & grant[gi];
            assign route[gi]       = in_data & (idx_reg == SEL_IDX);
            assign req_rvalid[gi]  = route[gi] & m_rvalid;
            assign req_rlast[gi]   = route[gi] & m_rlast;
        end
    endgenerate

    assign s0_arready = req_arready[0];
    assign s1_arready = req_arready[1];
    assign s0_rvalid  = req_rvalid[0];
    assign s1_rvalid  = req_rvalid[1];
    assign s0_rlast   = req_rlast[0];
    assign s1_rlast   = req_rlast[1];
    assign s0_rdata   = m_rdata;
    assign s1_rdata   = m_rdata;
    assign s0_rresp   = m_rresp;
    assign s1_rresp   = m_rresp;

    assign m_rready  = in_data & req_rready[idx_reg];
    assign beat      = in_data & m_rvalid & m_rready;

    assign m_arid    = C_AXI_ID_WIDTH'(idx_reg);
    assign m_araddr  = addr_reg;
    assign m_arlen   = len_reg;
    assign m_arsize  = ARSIZE;
    assign m_arburst = 2'b01;
    assign m_arvalid = m_arvalid_reg;
    assign len_err   = len_err_reg;

    // Arbitration FSM: capture the winner, present its address, then count its beats.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_reg     <= ST_IDLE;
            prio_reg      <= 1'b0;
            idx_reg       <= 1'b0;
            len_err_reg   <= 1'b0;
            m_arvalid_reg <= 1'b0;
            addr_reg      <= '0;
            len_reg       <= '0;
            beat_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        addr_reg      <= req_araddr[win_idx];
                        len_reg       <= req_arlen[win_idx];
                        idx_reg       <= win_idx;
                        m_arvalid_reg <= 1'b1;
                        state_reg     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        m_arvalid_reg <= 1'b0;
                        beat_cnt_reg  <= '0;
                        state_reg     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + 9'd1;
                        // Early last, or a non-last beat at the final index, both flag a length error.
                        if (m_rlast && (beat_cnt_reg != {1'b0, len_reg})) begin
                            len_err_reg <= 1'b1;
                        end
                        if (!m_rlast && (beat_cnt_reg == {1'b0, len_reg})) begin
                            len_err_reg <= 1'b1;
                        end
                        if (m_rlast) begin
                            prio_reg  <= ~idx_reg;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
